// File: rtl/lisp_defs.sv
// Shared Lisp cell-memory definitions: NIL pointer, cell type tags, primop codes
// and the error codes reported by list_walker.
package lisp_defs;
    localparam logic [15:0] NIL            = 16'h0000;
    localparam logic [14:0] TYPE_NUMBER    = 15'd1;
    localparam logic [14:0] TYPE_CONS      = 15'd2;
    localparam logic [14:0] TYPE_PRIMITIVE = 15'd3;
    localparam logic [15:0] PRIMOP_ADD     = 16'h0001;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_NOT_CONS = 2'd1,
        ERR_TOO_LONG = 2'd2
    } walk_err_t;
endpackage

// File: rtl/list_walker.sv
// Walks a cons list from a root pointer and streams each car over valid/ready.
// Define LIST_WALKER_DEREF_EN to also read each element cell (type + car).
module list_walker
    import lisp_defs::*;
#(
    parameter int unsigned MaxLen = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] list_ptr,
    output logic        busy,
    output logic        mem_read_enable,
    output logic [15:0] mem_addr,
    input  logic [14:0] mem_header,
    input  logic [15:0] mem_car,
    input  logic [15:0] mem_cdr,
    input  logic        mem_done,
    output logic        elem_valid,
    input  logic        elem_ready,
    output logic [15:0] elem_ptr,
    output logic [14:0] elem_type,
    output logic [15:0] elem_value,
    output logic        done,
    output logic [7:0]  count,
    output logic [1:0]  error
);
    // state        | meaning
    // S_IDLE       | waiting for start
    // S_FETCH_CONS | one-cycle read request for the current cons cell
    // S_WAIT_CONS  | waiting for the cons cell to arrive
    // S_FETCH_ELEM | one-cycle read request for the element cell (deref build)
    // S_WAIT_ELEM  | waiting for the element cell (deref build)
    // S_EMIT       | element presented to the consumer
    // S_FINISH     | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_CONS, S_WAIT_CONS, S_FETCH_ELEM, S_WAIT_ELEM, S_EMIT, S_FINISH
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MaxLen);

    state_t      state_q, state_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] next_ptr_q, next_ptr_d;
    logic [15:0] elem_ptr_q, elem_ptr_d;
    logic [7:0]  count_q, count_d;
    walk_err_t   error_q, error_d;
`ifdef LIST_WALKER_DEREF_EN
    logic [14:0] elem_type_q, elem_type_d;
    logic [15:0] elem_value_q, elem_value_d;
`endif

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        next_ptr_d = next_ptr_q;
        elem_ptr_d = elem_ptr_q;
        count_d    = count_q;
        error_d    = error_q;
`ifdef LIST_WALKER_DEREF_EN
        elem_type_d  = elem_type_q;
        elem_value_d = elem_value_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = 8'd0;
                    error_d = ERR_NONE;
                    if (list_ptr == NIL) begin
                        state_d = S_FINISH;
                    end else begin
                        mem_addr_d = list_ptr;
                        state_d    = S_FETCH_CONS;
                    end
                end
            end
            S_FETCH_CONS: state_d = S_WAIT_CONS;
            S_WAIT_CONS: begin
                if (mem_done) begin
                    if (mem_header != TYPE_CONS) begin
                        error_d = ERR_NOT_CONS;
                        state_d = S_FINISH;
                    end else begin
                        elem_ptr_d = mem_car;
                        next_ptr_d = mem_cdr;
`ifdef LIST_WALKER_DEREF_EN
                        if (mem_car != NIL) begin
                            mem_addr_d = mem_car;
                            state_d    = S_FETCH_ELEM;
                        end else begin
                            elem_type_d  = 15'd0;
                            elem_value_d = 16'd0;
                            state_d      = S_EMIT;
                        end
`else
                        state_d = S_EMIT;
`endif
                    end
                end
            end
`ifdef LIST_WALKER_DEREF_EN
            S_FETCH_ELEM: state_d = S_WAIT_ELEM;
            S_WAIT_ELEM: begin
                if (mem_done) begin
                    elem_type_d  = mem_header;
                    elem_value_d = mem_car;
                    state_d      = S_EMIT;
                end
            end
`endif
            S_EMIT: begin
                if (elem_ready) begin
                    if (count_q < MAX_CNT) count_d = count_q + 8'd1;
                    // The length guard stops before issuing a read for the next cell.
                    if (next_ptr_q == NIL) begin
                        state_d = S_FINISH;
                    end else if (count_d == MAX_CNT) begin
                        error_d = ERR_TOO_LONG;
                        state_d = S_FINISH;
                    end else begin
                        mem_addr_d = next_ptr_q;
                        state_d    = S_FETCH_CONS;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mem_addr_q <= 16'd0;
            next_ptr_q <= 16'd0;
            elem_ptr_q <= 16'd0;
            count_q    <= 8'd0;
            error_q    <= ERR_NONE;
`ifdef LIST_WALKER_DEREF_EN
            elem_type_q  <= 15'd0;
            elem_value_q <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            next_ptr_q <= next_ptr_d;
            elem_ptr_q <= elem_ptr_d;
            count_q    <= count_d;
            error_q    <= error_d;
`ifdef LIST_WALKER_DEREF_EN
            elem_type_q  <= elem_type_d;
            elem_value_q <= elem_value_d;
`endif
        end
    end

    assign busy            = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign mem_read_enable = (state_q == S_FETCH_CONS) || (state_q == S_FETCH_ELEM);
    assign mem_addr        = mem_addr_q;
    assign elem_valid      = (state_q == S_EMIT);
    assign elem_ptr        = elem_ptr_q;
    assign done            = (state_q == S_FINISH);
    assign count           = count_q;
    assign error           = error_q;
`ifdef LIST_WALKER_DEREF_EN
    assign elem_type  = elem_type_q;
    assign elem_value = elem_value_q;
`else
    assign elem_type  = 15'd0;
    assign elem_value = 16'd0;
`endif
endmodule

// File: tb/tb_list_walker.sv
// Self-checking bench for list_walker: default instance plus a MaxLen=2 instance
// sharing one preloaded cell memory with variable read latency.
module tb_list_walker;
    import lisp_defs::*;

`ifdef LIST_WALKER_DEREF_EN
    localparam bit DEREF = 1'b1;
`else
    localparam bit DEREF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] list_ptr = 16'd0;
    logic        elem_ready = 1'b1;
    logic [14:0] mem_header = '0;
    logic [15:0] mem_car = '0, mem_cdr = '0;
    logic        mem_done = 1'b0;

    logic        busy_a, re_a, ev_a, done_a, busy_b, re_b, ev_b, done_b;
    logic [15:0] addr_a, eptr_a, eval_a, addr_b, eptr_b, eval_b;
    logic [14:0] etype_a, etype_b;
    logic [7:0]  count_a, count_b;
    logic [1:0]  error_a, error_b;

    list_walker dut_a (
        .clk(clk), .rst(rst), .start(start_a), .list_ptr(list_ptr), .busy(busy_a),
        .mem_read_enable(re_a), .mem_addr(addr_a), .mem_header(mem_header),
        .mem_car(mem_car), .mem_cdr(mem_cdr), .mem_done(mem_done),
        .elem_valid(ev_a), .elem_ready(elem_ready), .elem_ptr(eptr_a),
        .elem_type(etype_a), .elem_value(eval_a), .done(done_a),
        .count(count_a), .error(error_a));

    list_walker #(.MaxLen(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .list_ptr(list_ptr), .busy(busy_b),
        .mem_read_enable(re_b), .mem_addr(addr_b), .mem_header(mem_header),
        .mem_car(mem_car), .mem_cdr(mem_cdr), .mem_done(mem_done),
        .elem_valid(ev_b), .elem_ready(elem_ready), .elem_ptr(eptr_b),
        .elem_type(etype_b), .elem_value(eval_b), .done(done_b),
        .count(count_b), .error(error_b));

    // Cell memory: word 0 = header, word 1 = car, word 2 = cdr.
    logic [15:0] mem [0:63];
    int          spur_req = 0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'd0;
        mem[6'h03] = 16'(TYPE_NUMBER);    mem[6'h04] = 16'd5;      mem[6'h05] = NIL;
        mem[6'h06] = 16'(TYPE_NUMBER);    mem[6'h07] = 16'd3;      mem[6'h08] = NIL;
        mem[6'h0F] = 16'(TYPE_CONS);      mem[6'h10] = 16'h0012;   mem[6'h11] = 16'h0015;
        mem[6'h12] = 16'(TYPE_PRIMITIVE); mem[6'h13] = PRIMOP_ADD; mem[6'h14] = NIL;
        mem[6'h15] = 16'(TYPE_CONS);      mem[6'h16] = 16'h0003;   mem[6'h17] = 16'h0018;
        mem[6'h18] = 16'(TYPE_CONS);      mem[6'h19] = 16'h0006;   mem[6'h1A] = NIL;
        mem[6'h1B] = 16'(TYPE_CONS);      mem[6'h1C] = 16'h0006;   mem[6'h1D] = 16'h0003;
        mem[6'h1E] = 16'(TYPE_CONS);      mem[6'h1F] = NIL;        mem[6'h20] = NIL;
    end

    // Memory responder; also emits a stray mem_done when asked so Idle can be probed.
    initial begin : responder
        int          spur_seen;
        logic [15:0] a;
        spur_seen = 0;
        forever begin
            @(negedge clk);
            if (re_a || re_b) begin
                a = re_a ? addr_a : addr_b;
                repeat (1 + int'(a % 16'd3)) @(posedge clk);
                #1;
                mem_header = mem[a[5:0]][14:0];
                mem_car    = mem[a[5:0] + 6'd1];
                mem_cdr    = mem[a[5:0] + 6'd2];
                mem_done   = 1'b1;
                @(posedge clk); #1;
                mem_done   = 1'b0;
            end else if (spur_req != spur_seen) begin
                spur_seen  = spur_req;
                @(posedge clk); #1;
                mem_header = TYPE_CONS;
                mem_car    = 16'h0006;
                mem_cdr    = NIL;
                mem_done   = 1'b1;
                @(posedge clk); #1;
                mem_done   = 1'b0;
            end
        end
    end

    // Monitor: records accepted elements, done pulses and read requests.
    logic [15:0] acc_ptr [0:255];
    logic [14:0] acc_type[0:255];
    logic [15:0] acc_val [0:255];
    int          acc_n = 0, done_n = 0, re_n = 0;
    logic [7:0]  done_cnt = '0;
    logic [1:0]  done_err = '0;

    always @(negedge clk) begin
        if (re_a || re_b) re_n <= re_n + 1;
        if (ev_a && elem_ready) begin
            acc_ptr[acc_n[7:0]] <= eptr_a; acc_type[acc_n[7:0]] <= etype_a;
            acc_val[acc_n[7:0]] <= eval_a; acc_n <= acc_n + 1;
        end else if (ev_b && elem_ready) begin
            acc_ptr[acc_n[7:0]] <= eptr_b; acc_type[acc_n[7:0]] <= etype_b;
            acc_val[acc_n[7:0]] <= eval_b; acc_n <= acc_n + 1;
        end
        if (done_a) begin
            done_n <= done_n + 1; done_cnt <= count_a; done_err <= error_a;
        end else if (done_b) begin
            done_n <= done_n + 1; done_cnt <= count_b; done_err <= error_b;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick_sample();
        @(negedge clk); #1;
    endtask

    typedef struct {
        bit              inst_b;
        logic [15:0]     root;
        int              n;
        logic [0:2][15:0] p;
        logic [0:2][14:0] t;
        logic [0:2][15:0] v;
        logic [1:0]      err;
    } vec_t;

    function automatic vec_t mk(bit ib, logic [15:0] root, int n, logic [47:0] p,
                                logic [44:0] t, logic [47:0] v, logic [1:0] err);
        vec_t r;
        r.inst_b = ib; r.root = root; r.n = n; r.p = p; r.t = t; r.v = v; r.err = err;
        return r;
    endfunction

    task automatic wait_done(input int dbase, input string name);
        int k;
        k = 0;
        while (done_n == dbase && k < 300) begin
            tick_sample();
            k++;
        end
        if (done_n == dbase) begin
            n_chk++; n_fail++;
            $display("FAIL %s: timeout waiting for done", name);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int    base, dbase, rbase;
        string nm;
        nm    = $sformatf("vec%0d", idx);
        base  = acc_n; dbase = done_n; rbase = re_n;
        list_ptr = v.root;
        if (v.inst_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        wait_done(dbase, nm);
        repeat (3) tick_sample();
        chk({nm, " done_pulses"}, 32'(done_n - dbase), 32'd1);
        chk({nm, " count"}, 32'(done_cnt), 32'(v.n));
        chk({nm, " error"}, 32'(done_err), 32'(v.err));
        chk({nm, " n_elems"}, 32'(acc_n - base), 32'(v.n));
        for (int i = 0; i < v.n && i < 3 && (base + i) < acc_n; i++) begin
            chk($sformatf("%s e%0d ptr", nm, i), 32'(acc_ptr[(base + i) % 256]), 32'(v.p[i]));
            chk($sformatf("%s e%0d type", nm, i), 32'(acc_type[(base + i) % 256]),
                DEREF ? 32'(v.t[i]) : 32'd0);
            chk($sformatf("%s e%0d value", nm, i), 32'(acc_val[(base + i) % 256]),
                DEREF ? 32'(v.v[i]) : 32'd0);
        end
        if (v.root == NIL) chk({nm, " no_reads"}, 32'(re_n - rbase), 32'd0);
        chk({nm, " held_count"}, 32'(v.inst_b ? count_b : count_a), 32'(v.n));
        chk({nm, " held_error"}, 32'(v.inst_b ? error_b : error_a), 32'(v.err));
        chk({nm, " busy_low"}, 32'(busy_a | busy_b), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        int base, dbase, k;
        vecs[0] = mk(0, 16'h000F, 3, {16'h0012, 16'h0003, 16'h0006},
                     {TYPE_PRIMITIVE, TYPE_NUMBER, TYPE_NUMBER}, {PRIMOP_ADD, 16'd5, 16'd3}, ERR_NONE);
        vecs[1] = mk(0, NIL,      0, '0, '0, '0, ERR_NONE);
        vecs[2] = mk(0, 16'h0003, 0, '0, '0, '0, ERR_NOT_CONS);
        vecs[3] = mk(0, 16'h0018, 1, {16'h0006, 32'h0}, {TYPE_NUMBER, 30'h0}, {16'd3, 32'h0}, ERR_NONE);
        vecs[4] = mk(0, 16'h001B, 1, {16'h0006, 32'h0}, {TYPE_NUMBER, 30'h0}, {16'd3, 32'h0}, ERR_NOT_CONS);
        vecs[5] = mk(0, 16'h001E, 1, '0, '0, '0, ERR_NONE);
        vecs[6] = mk(1, 16'h000F, 2, {16'h0012, 16'h0003, 16'h0}, {TYPE_PRIMITIVE, TYPE_NUMBER, 15'h0},
                     {PRIMOP_ADD, 16'd5, 16'h0}, ERR_TOO_LONG);
        vecs[7] = mk(1, 16'h0015, 2, {16'h0003, 16'h0006, 16'h0}, {TYPE_NUMBER, TYPE_NUMBER, 15'h0},
                     {16'd5, 16'd3, 16'h0}, ERR_NONE);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick_sample();
        chk("reset busy", 32'(busy_a), 0);
        chk("reset re", 32'(re_a), 0);
        chk("reset valid", 32'(ev_a), 0);
        chk("reset done", 32'(done_a), 0);
        chk("reset addr", 32'(addr_a), 0);
        chk("reset count", 32'(count_a), 0);
        chk("reset error", 32'(error_a), 32'(ERR_NONE));

        // Stray mem_done while idle must not start anything.
        spur_req = 1;
        repeat (4) tick_sample();
        chk("idle mem_done busy", 32'(busy_a), 0);
        chk("idle mem_done done_n", 32'(done_n), 0);
        chk("idle mem_done valid", 32'(ev_a), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Empty list: done in the cycle right after start is taken.
        list_ptr = NIL; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        tick_sample();
        chk("nil done_timing", 32'(done_a), 1);
        tick_sample();
        chk("nil done_single", 32'(done_a), 0);

        // Back-pressure on the second element, with a stray start mid-walk.
        base = acc_n; dbase = done_n;
        elem_ready = 1'b1; list_ptr = 16'h000F; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        k = 0;
        while (acc_n == base && k < 100) begin tick_sample(); k++; end
        @(posedge clk); #1 elem_ready = 1'b0;
        k = 0;
        while (!ev_a && k < 100) begin tick_sample(); k++; end
        chk("stall reached_elem2", 32'(ev_a), 1);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin list_ptr = NIL; start_a = 1'b1; end
            if (c == 2) start_a = 1'b0;
            tick_sample();
            chk($sformatf("stall c%0d valid", c), 32'(ev_a), 1);
            chk($sformatf("stall c%0d ptr", c), 32'(eptr_a), 32'h0003);
        end
        start_a = 1'b0;
        @(posedge clk); #1 elem_ready = 1'b1;
        wait_done(dbase, "stall");
        repeat (3) tick_sample();
        chk("stall n_elems", 32'(acc_n - base), 3);
        chk("stall count", 32'(done_cnt), 3);
        chk("stall error", 32'(done_err), 32'(ERR_NONE));
        chk("stall done_pulses", 32'(done_n - dbase), 1);
        if (acc_n - base == 3) begin
            chk("stall e0", 32'(acc_ptr[base % 256]), 32'h0012);
            chk("stall e1", 32'(acc_ptr[(base + 1) % 256]), 32'h0003);
            chk("stall e2", 32'(acc_ptr[(base + 2) % 256]), 32'h0006);
        end

        // Reset while waiting on the first cons read.
        dbase = done_n;
        list_ptr = 16'h000F; start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        k = re_n;
        while (re_n == k && k < 1000000) tick_sample();
        @(posedge clk); #1 rst = 1'b1;
        chk("rst_mid busy_before", 32'(busy_a), 1);
        @(posedge clk); #1 rst = 1'b0;
        tick_sample();
        chk("rst_mid busy", 32'(busy_a), 0);
        chk("rst_mid re", 32'(re_a), 0);
        chk("rst_mid valid", 32'(ev_a), 0);
        chk("rst_mid addr", 32'(addr_a), 0);
        chk("rst_mid elem_ptr", 32'(eptr_a), 0);
        chk("rst_mid count", 32'(count_a), 0);
        chk("rst_mid error", 32'(error_a), 32'(ERR_NONE));
        repeat (8) tick_sample();
        chk("rst_mid no_done", 32'(done_n - dbase), 0);
        chk("rst_mid still_idle", 32'(busy_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
